// File: rtl/dist_law_pkg.sv
// Shared definitions for the sequential distributive-law checker: FSM encoding and default widths.
package dist_law_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_M1   = 3'd1;
  localparam logic [2:0] ST_M2   = 3'd2;
  localparam logic [2:0] ST_M3   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/booth_seq_mul.sv
// Iterative radix-2 Booth multiplier: one recoding step per cycle, W cycles per product.
// The start cycle performs the first step; done and prod are valid in the W-th cycle.
module booth_seq_mul #(
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic signed [W-1:0]   m,
  input  logic signed [W-1:0]   q,
  output logic                  done,
  output logic signed [2*W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  // Accumulator carries one guard bit so that -M stays exact for M = -2^(W-1).
  logic signed [W:0]   r_acc;
  logic        [W-1:0] r_q;
  logic                r_q1;
  logic        [CW-1:0] r_cnt;
  logic                r_busy;

  logic signed [W:0]   w_m_ext;
  logic signed [W:0]   w_acc_cur;
  logic        [W-1:0] w_q_cur;
  logic                w_q1_cur;
  logic        [CW-1:0] w_cnt_cur;
  logic signed [W:0]   w_acc_add;
  logic signed [W:0]   w_acc_nxt;
  logic        [W-1:0] w_q_nxt;
  logic                w_q1_nxt;

  always_comb begin
    w_m_ext   = {m[W-1], m};
    w_acc_cur = start ? '0 : r_acc;
    w_q_cur   = start ? q : r_q;
    w_q1_cur  = start ? 1'b0 : r_q1;
    w_cnt_cur = start ? '0 : r_cnt;
    case ({w_q_cur[0], w_q1_cur})
      2'b01:   w_acc_add = w_acc_cur + w_m_ext;
      2'b10:   w_acc_add = w_acc_cur - w_m_ext;
      default: w_acc_add = w_acc_cur;
    endcase
    w_acc_nxt = {w_acc_add[W], w_acc_add[W:1]};
    w_q_nxt   = {w_acc_add[0], w_q_cur[W-1:1]};
    w_q1_nxt  = w_q_cur[0];
    done      = (start || r_busy) && (w_cnt_cur == CW'(W - 1));
    prod      = {w_acc_nxt[W-1:0], w_q_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start || r_busy) begin
      r_busy <= !done;
      r_cnt  <= w_cnt_cur + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start || r_busy) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_q1  <= w_q1_nxt;
    end
  end

endmodule

// File: rtl/dist_law_seq_checker.sv
// Sequential distributive-law checker: a*(b+c) vs a*b+a*c on one shared Booth multiplier.
// Optional macro DIST_LAW_OVF_DETECT_EN adds sum_ovf/ovf_cnt and moves explained mismatches off fail_cnt.
module dist_law_seq_checker
  import dist_law_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  input  logic signed [W-1:0]   c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] out1,
  output logic signed [2*W-1:0] out2,
  output logic                  match,
`ifdef DIST_LAW_OVF_DETECT_EN
  output logic                  sum_ovf,
  output logic [CNT_W-1:0]      ovf_cnt,
`endif
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [2:0]             r_state;
  logic                   r_start;
  logic signed [W-1:0]    r_a;
  logic signed [W-1:0]    r_b;
  logic signed [W-1:0]    r_c;
  logic signed [W-1:0]    r_s;
  logic signed [2*W-1:0]  r_p1;
  logic signed [2*W-1:0]  r_p2;
  logic signed [2*W-1:0]  r_out1;
  logic signed [2*W-1:0]  r_out2;
  logic                   r_match;
  logic [CNT_W-1:0]       r_pass_cnt;
  logic [CNT_W-1:0]       r_fail_cnt;

  logic                   w_fire_in;
  logic                   w_fire_out;
  logic signed [W-1:0]    w_in_sum;
  logic signed [W-1:0]    w_mul_q;
  logic                   w_mul_done;
  logic signed [2*W-1:0]  w_mul_prod;
  logic signed [2*W-1:0]  w_sum;

`ifdef DIST_LAW_OVF_DETECT_EN
  logic                   r_ovf_in;
  logic                   r_sum_ovf;
  logic [CNT_W-1:0]       r_ovf_cnt;
  assign sum_ovf = r_sum_ovf;
  assign ovf_cnt = r_ovf_cnt;
`endif

  always_comb begin
    w_fire_in  = in_valid && (r_state == ST_IDLE);
    w_fire_out = out_ready && (r_state == ST_RESP);
    w_in_sum   = b + c;
    case (r_state)
      ST_M1:   w_mul_q = r_s;
      ST_M2:   w_mul_q = r_b;
      default: w_mul_q = r_c;
    endcase
    w_sum = r_p2 + w_mul_prod;
  end

  booth_seq_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (r_start),
    .m     (r_a),
    .q     (w_mul_q),
    .done  (w_mul_done),
    .prod  (w_mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_start    <= 1'b0;
      r_out1     <= '0;
      r_out2     <= '0;
      r_match    <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
`ifdef DIST_LAW_OVF_DETECT_EN
      r_sum_ovf  <= 1'b0;
      r_ovf_cnt  <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_fire_in) begin
          r_state <= ST_M1;
          r_start <= 1'b1;
        end
        ST_M1: if (w_mul_done) begin
          r_state <= ST_M2;
          r_start <= 1'b1;
        end
        ST_M2: if (w_mul_done) begin
          r_state <= ST_M3;
          r_start <= 1'b1;
        end
        ST_M3: if (w_mul_done) begin
          r_state <= ST_RESP;
          r_out1  <= r_p1;
          r_out2  <= w_sum;
          r_match <= (r_p1 == w_sum);
`ifdef DIST_LAW_OVF_DETECT_EN
          r_sum_ovf <= r_ovf_in;
`endif
        end
        ST_RESP: if (w_fire_out) begin
          r_state <= ST_IDLE;
          if (r_match) r_pass_cnt <= sat_inc(r_pass_cnt);
`ifdef DIST_LAW_OVF_DETECT_EN
          else if (r_sum_ovf) r_ovf_cnt <= sat_inc(r_ovf_cnt);
`endif
          else r_fail_cnt <= sat_inc(r_fail_cnt);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand and partial-product registers carry no reset; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (w_fire_in) begin
      r_a <= a;
      r_b <= b;
      r_c <= c;
      r_s <= w_in_sum;
`ifdef DIST_LAW_OVF_DETECT_EN
      r_ovf_in <= (b[W-1] == c[W-1]) && (w_in_sum[W-1] != b[W-1]);
`endif
    end
    if (r_state == ST_M1 && w_mul_done) r_p1 <= w_mul_prod;
    if (r_state == ST_M2 && w_mul_done) r_p2 <= w_mul_prod;
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_RESP);
  assign out1      = r_out1;
  assign out2      = r_out2;
  assign match     = r_match;
  assign pass_cnt  = r_pass_cnt;
  assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_dist_law_seq_checker.sv
// Bench for dist_law_seq_checker: scenario tasks against an arithmetic reference model.
// Honours DIST_LAW_OVF_DETECT_EN when the design is built with it.
module tb_dist_law_seq_checker;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int LAT   = 3 * W;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   a, b, c;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*W-1:0] out1, out2;
  logic                  match;
  logic [CNT_W-1:0]      pass_cnt, fail_cnt;
`ifdef DIST_LAW_OVF_DETECT_EN
  logic                  sum_ovf;
  logic [CNT_W-1:0]      ovf_cnt;
`endif

  logic                  m_start;
  logic signed [W-1:0]   m_m, m_q;
  logic                  m_done;
  logic signed [2*W-1:0] m_prod;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass = 0;
  int exp_fail = 0;
  int exp_ovf  = 0;

  always #5 clk = ~clk;

  dist_law_seq_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .match     (match),
`ifdef DIST_LAW_OVF_DETECT_EN
    .sum_ovf   (sum_ovf),
    .ovf_cnt   (ovf_cnt),
`endif
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
  );

  booth_seq_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (m_start),
    .m     (m_m),
    .q     (m_q),
    .done  (m_done),
    .prod  (m_prod)
  );

  // Reference: plain integer arithmetic, results wrapped to the widths the block reports.
  function automatic int wrap(input int v, input int bits);
    return ((v + (1 << (bits - 1))) & ((1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  task automatic model(input int ta, input int tb_, input int tc,
                       output logic signed [2*W-1:0] e1, output logic signed [2*W-1:0] e2,
                       output logic em, output logic eov);
    int s, r1, r2;
    s   = wrap(tb_ + tc, W);
    r1  = wrap(ta * s, 2 * W);
    r2  = wrap(ta * tb_ + ta * tc, 2 * W);
    e1  = r1[2*W-1:0];
    e2  = r2[2*W-1:0];
    em  = (r1 == r2);
    eov = (tb_ + tc) != s;
  endtask

  task automatic count_result(input logic em, input logic eov);
    if (em) exp_pass = (exp_pass < SAT) ? exp_pass + 1 : SAT;
`ifdef DIST_LAW_OVF_DETECT_EN
    else if (eov) exp_ovf = (exp_ovf < SAT) ? exp_ovf + 1 : SAT;
`endif
    else exp_fail = (exp_fail < SAT) ? exp_fail + 1 : SAT;
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  // Called at a negedge with the block idle; returns at the negedge where out_valid is first seen.
  task automatic issue_and_wait(input int ta, input int tb_, input int tc, output int lat);
    a = ta[W-1:0];
    b = tb_[W-1:0];
    c = tc[W-1:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; m_start = 1'b0;
    a = '0; b = '0; c = '0; m_m = '0; m_q = '0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out1 !== '0 || out2 !== '0) begin n_fail++; $display("FAIL reset_outs got %h/%h want 00/00", out1, out2); end
    if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b want 0", match); end
    if (pass_cnt !== '0) begin n_fail++; $display("FAIL reset_pass got %0d want 0", pass_cnt); end
    if (fail_cnt !== '0) begin n_fail++; $display("FAIL reset_fail got %0d want 0", fail_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Directed triples from the block's reference cases, each checked against the model.
  task automatic test_directed();
    int vec [3][3] = '{'{3, 2, 1}, '{3, 7, 1}, '{-8, -8, -8}};
    int lat;
    logic signed [2*W-1:0] e1, e2;
    logic em, eov;
    for (int i = 0; i < 3; i++) begin
      model(vec[i][0], vec[i][1], vec[i][2], e1, e2, em, eov);
      issue_and_wait(vec[i][0], vec[i][1], vec[i][2], lat);
      n_checks += 4;
      if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      if (out1 !== e1) begin n_fail++; $display("FAIL dir%0d_out1 got %0d want %0d", i, out1, e1); end
      if (out2 !== e2) begin n_fail++; $display("FAIL dir%0d_out2 got %0d want %0d", i, out2, e2); end
      if (match !== em) begin n_fail++; $display("FAIL dir%0d_match got %b want %b", i, match, em); end
`ifdef DIST_LAW_OVF_DETECT_EN
      n_checks++;
      if (sum_ovf !== eov) begin n_fail++; $display("FAIL dir%0d_sum_ovf got %b want %b", i, sum_ovf, eov); end
`endif
      release_out();
      count_result(em, eov);
      n_checks += 2;
      if (pass_cnt !== exp_pass[CNT_W-1:0]) begin n_fail++; $display("FAIL dir%0d_pass_cnt got %0d want %0d", i, pass_cnt, exp_pass); end
      if (fail_cnt !== exp_fail[CNT_W-1:0]) begin n_fail++; $display("FAIL dir%0d_fail_cnt got %0d want %0d", i, fail_cnt, exp_fail); end
`ifdef DIST_LAW_OVF_DETECT_EN
      n_checks++;
      if (ovf_cnt !== exp_ovf[CNT_W-1:0]) begin n_fail++; $display("FAIL dir%0d_ovf_cnt got %0d want %0d", i, ovf_cnt, exp_ovf); end
`endif
    end
    n_checks++;
    if (exp_pass != 1) begin n_fail++; $display("FAIL dir_first_pass model %0d want 1", exp_pass); end
  endtask

  task automatic test_booth_alone();
    int mm, qq, cyc, ref_p;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin mm = -8; qq = -8; end
      else if (i == 1) begin mm = -8; qq = 7; end
      else begin mm = rnd_op(); qq = rnd_op(); end
      ref_p = mm * qq;
      m_m = mm[W-1:0];
      m_q = qq[W-1:0];
      m_start = 1'b1;
      cyc = 1;
      #1;
      while (!m_done && cyc < 20) begin
        @(posedge clk);
        @(negedge clk);
        m_start = 1'b0;
        cyc++;
        #1;
      end
      n_checks += 2;
      if (cyc != W) begin n_fail++; $display("FAIL mul%0d_cycles got %0d want %0d", i, cyc, W); end
      if (m_prod !== ref_p[2*W-1:0]) begin n_fail++; $display("FAIL mul%0d_prod %0d*%0d got %0d want %0d", i, mm, qq, m_prod, ref_p); end
      @(posedge clk);
      @(negedge clk);
      m_start = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic signed [2*W-1:0] e1, e2, h1, h2;
    logic em, eov, hm;
    logic [CNT_W-1:0] hp, hf;
    model(2, 3, -1, e1, e2, em, eov);
    issue_and_wait(2, 3, -1, lat);
    h1 = out1; h2 = out2; hm = match; hp = pass_cnt; hf = fail_cnt;
    n_checks += 2;
    if (out1 !== e1 || out2 !== e2) begin n_fail++; $display("FAIL bp_result got %0d/%0d want %0d/%0d", out1, out2, e1, e2); end
    if (lat != LAT) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
    // Offer a different triple while stalled; it must be ignored.
    a = 4'sd1; b = 4'sd1; c = 4'sd1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks += 4;
      if (out1 !== h1 || out2 !== h2 || match !== hm) begin n_fail++; $display("FAIL bp_stable%0d got %0d/%0d/%b want %0d/%0d/%b", i, out1, out2, match, h1, h2, hm); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d got %b want 1", i, out_valid); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
      if (pass_cnt !== hp || fail_cnt !== hf) begin n_fail++; $display("FAIL bp_counters%0d got %0d/%0d want %0d/%0d", i, pass_cnt, fail_cnt, hp, hf); end
    end
    in_valid = 1'b0;
    release_out();
    count_result(em, eov);
    n_checks += 3;
    if (pass_cnt !== exp_pass[CNT_W-1:0]) begin n_fail++; $display("FAIL bp_pass_after got %0d want %0d", pass_cnt, exp_pass); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle got in_ready %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic signed [2*W-1:0] e1, e2;
    logic em, eov;
    a = 4'sd5; b = 4'sd1; c = 4'sd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Five more edges put the FSM in the second multiply.
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_pass = 0; exp_fail = 0; exp_ovf = 0;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    if (pass_cnt !== '0) begin n_fail++; $display("FAIL rstmid_pass got %0d want 0", pass_cnt); end
    if (fail_cnt !== '0) begin n_fail++; $display("FAIL rstmid_fail got %0d want 0", fail_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model(2, 1, 1, e1, e2, em, eov);
    issue_and_wait(2, 1, 1, lat);
    n_checks += 3;
    if (lat != LAT) begin n_fail++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    if (out1 !== e1 || out2 !== e2) begin n_fail++; $display("FAIL rstmid_result got %0d/%0d want %0d/%0d", out1, out2, e1, e2); end
    if (match !== em) begin n_fail++; $display("FAIL rstmid_match got %b want %b", match, em); end
    release_out();
    count_result(em, eov);
    n_checks++;
    if (pass_cnt !== exp_pass[CNT_W-1:0]) begin n_fail++; $display("FAIL rstmid_pass_after got %0d want %0d", pass_cnt, exp_pass); end
  endtask

  task automatic test_random();
    int ta, tb_, tc, lat;
    logic signed [2*W-1:0] e1, e2;
    logic em, eov;
    for (int i = 0; i < 40; i++) begin
      ta = rnd_op(); tb_ = rnd_op(); tc = rnd_op();
      model(ta, tb_, tc, e1, e2, em, eov);
      issue_and_wait(ta, tb_, tc, lat);
      n_checks += 4;
      if (lat != LAT) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); end
      if (out1 !== e1) begin n_fail++; $display("FAIL rnd%0d_out1 (%0d,%0d,%0d) got %0d want %0d", i, ta, tb_, tc, out1, e1); end
      if (out2 !== e2) begin n_fail++; $display("FAIL rnd%0d_out2 (%0d,%0d,%0d) got %0d want %0d", i, ta, tb_, tc, out2, e2); end
      if (match !== em) begin n_fail++; $display("FAIL rnd%0d_match got %b want %b", i, match, em); end
`ifdef DIST_LAW_OVF_DETECT_EN
      n_checks++;
      if (sum_ovf !== eov) begin n_fail++; $display("FAIL rnd%0d_sum_ovf got %b want %b", i, sum_ovf, eov); end
`endif
      release_out();
      count_result(em, eov);
      n_checks += 2;
      if (pass_cnt !== exp_pass[CNT_W-1:0]) begin n_fail++; $display("FAIL rnd%0d_pass_cnt got %0d want %0d", i, pass_cnt, exp_pass); end
      if (fail_cnt !== exp_fail[CNT_W-1:0]) begin n_fail++; $display("FAIL rnd%0d_fail_cnt got %0d want %0d", i, fail_cnt, exp_fail); end
`ifdef DIST_LAW_OVF_DETECT_EN
      n_checks++;
      if (ovf_cnt !== exp_ovf[CNT_W-1:0]) begin n_fail++; $display("FAIL rnd%0d_ovf_cnt got %0d want %0d", i, ovf_cnt, exp_ovf); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int ta, tb_, tc, lat;
    logic signed [2*W-1:0] e1, e2;
    logic em, eov;
    for (int i = 0; i < 300; i++) begin
      ta = rnd_op();
      do begin tb_ = rnd_op(); tc = rnd_op(); end while (tb_ + tc > 7 || tb_ + tc < -8);
      model(ta, tb_, tc, e1, e2, em, eov);
      issue_and_wait(ta, tb_, tc, lat);
      n_checks += 2;
      if (match !== 1'b1 || out1 !== e1) begin n_fail++; $display("FAIL b2b%0d_result got %0d/%b want %0d/1", i, out1, match, e1); end
      if (lat != LAT) begin n_fail++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, LAT); end
      release_out();
      count_result(em, eov);
      n_checks += 2;
      if (pass_cnt !== exp_pass[CNT_W-1:0]) begin n_fail++; $display("FAIL b2b%0d_pass_cnt got %0d want %0d", i, pass_cnt, exp_pass); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got %b want 1", i, in_ready); end
    end
    n_checks += 2;
    if (pass_cnt !== 8'hFF) begin n_fail++; $display("FAIL b2b_saturated got %0d want 255", pass_cnt); end
    if (fail_cnt !== exp_fail[CNT_W-1:0]) begin n_fail++; $display("FAIL b2b_fail_cnt got %0d want %0d", fail_cnt, exp_fail); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_booth_alone();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
